// File: rtl/correlator_source_pkg.sv
// Shared configuration for the correlator sample source.
// Holds the antenna width, time-multiplexing rate, phase-counter width,
// samples-per-bank counter width, bank counter width and default block size.
package correlator_source_pkg;

  localparam int unsigned CS_IBITS     = 24;
  localparam int unsigned CS_TRATE     = 12;
  localparam int unsigned CS_TBITS     = 4;
  localparam int unsigned CS_CBITS     = 24;
  localparam int unsigned CS_BANK_BITS = 8;
  localparam int unsigned CS_BLKSIZE   = 1023;

endpackage

// File: rtl/correlator_source_if.sv
// Antenna-in / correlator-out bundle of the correlator sample source.
// master: the source itself (takes enable/blksize/strobe/antenna bits,
//         drives en/re/im/sw/bank_o/overflow_o).
// slave:  the environment on the other side.
interface correlator_source_if
  import correlator_source_pkg::*;
#(
  parameter int unsigned IBITS = CS_IBITS,
  parameter int unsigned CBITS = CS_CBITS
);

  logic                    enable_i;
  logic [CBITS-1:0]        blksize_i;
  logic                    strobe_i;
  logic [IBITS-1:0]        ant_re_i;
  logic [IBITS-1:0]        ant_im_i;
  logic                    en;
  logic [IBITS-1:0]        re;
  logic [IBITS-1:0]        im;
  logic                    sw;
  logic [CS_BANK_BITS-1:0] bank_o;
  logic                    overflow_o;

  modport master (
    input  enable_i, blksize_i, strobe_i, ant_re_i, ant_im_i,
    output en, re, im, sw, bank_o, overflow_o
  );

  modport slave (
    output enable_i, blksize_i, strobe_i, ant_re_i, ant_im_i,
    input  en, re, im, sw, bank_o, overflow_o
  );

endinterface

// File: rtl/correlator_source_hold.sv
// One-entry hold register for antenna samples that arrive while the
// current sample is still being presented, with sticky overflow.
// Ports: clk, rst_n (async active-low); flush empties the entry;
//        clear_ovf clears the sticky flag; push offers din; pop takes dout;
//        full/dout give the entry; overflow is set when a push is dropped.
module correlator_source_hold #(
  parameter int unsigned W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         clear_ovf,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout,
  output logic         overflow
);

  // A push with a simultaneous pop refills the entry instead of overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      if (clear_ovf) begin
        overflow <= 1'b0;
      end else if (push && full && !pop) begin
        overflow <= 1'b1;
      end

      if (flush) begin
        full <= 1'b0;
      end else if (pop) begin
        full <= push;
        if (push) begin
          dout <= din;
        end
      end else if (push && !full) begin
        full <= 1'b1;
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/correlator_source.sv
// Correlator sample source: holds each antenna sample on re/im for TRATE
// clocks, queues one extra sample, counts samples into banks and pulses sw
// during the last cycle of the bank's final sample.
// Ports: clk_x, rst_n (async active-low); bus (master) carries
//        enable_i, blksize_i, strobe_i, ant_re_i/ant_im_i in and
//        en, re, im, sw, bank_o, overflow_o out.
module correlator_source
  import correlator_source_pkg::*;
#(
  parameter int unsigned IBITS = CS_IBITS,
  parameter int unsigned TRATE = CS_TRATE,
  parameter int unsigned TBITS = CS_TBITS,
  parameter int unsigned CBITS = CS_CBITS
) (
  input  logic               clk_x,
  input  logic               rst_n,
  correlator_source_if.master bus
);

  localparam int unsigned    BBITS      = CS_BANK_BITS;
  localparam int unsigned    HBITS      = 2 * IBITS;
  localparam logic [TBITS-1:0] LAST_PHASE = TBITS'(TRATE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic [TBITS-1:0]   phase, phase_nx;
  logic [CBITS-1:0]   cnt, cnt_nx;
  logic [CBITS-1:0]   blk, blk_nx;
  logic [BBITS-1:0]   bank, bank_nx;
  logic [IBITS-1:0]   re_q, re_nx;
  logic [IBITS-1:0]   im_q, im_nx;
  logic               en_q, en_nx;
  logic               sw_q, sw_nx;
  logic               enable_d;

  logic               accept;
  logic               rise;
  logic               flush;
  logic               load_slot;
  logic               h_push, h_pop, h_full, ovf;
  logic [HBITS-1:0]   h_data;

  assign accept = bus.enable_i & bus.strobe_i;
  assign rise   = bus.enable_i & ~enable_d;
  assign flush  = ~bus.enable_i;

  correlator_source_hold #(.W(HBITS)) u_hold (
    .clk       (clk_x),
    .rst_n     (rst_n),
    .flush     (flush),
    .clear_ovf (rise),
    .push      (h_push),
    .pop       (h_pop),
    .din       ({bus.ant_re_i, bus.ant_im_i}),
    .full      (h_full),
    .dout      (h_data),
    .overflow  (ovf)
  );

  // Next state, sample selection, bank counting and sw look-ahead.
  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    cnt_nx    = cnt;
    blk_nx    = blk;
    bank_nx   = bank;
    re_nx     = re_q;
    im_nx     = im_q;
    h_push    = 1'b0;
    h_pop     = 1'b0;
    load_slot = 1'b0;

    if (!bus.enable_i) begin
      // Drop the partial sample and restart the bank count; bank is kept.
      state_nx = IDLE;
      phase_nx = '0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: load_slot = 1'b1;
        RUN: begin
          if (phase == LAST_PHASE) begin
            load_slot = 1'b1;
            if (cnt == blk) begin
              cnt_nx  = '0;
              bank_nx = bank + BBITS'(1);
              blk_nx  = bus.blksize_i;
            end else begin
              cnt_nx = cnt + CBITS'(1);
            end
          end else begin
            phase_nx = phase + TBITS'(1);
            h_push   = accept;
          end
        end
        default: state_nx = IDLE;
      endcase

      // Held sample has priority; a concurrent strobe takes its place.
      if (load_slot) begin
        phase_nx = '0;
        if (h_full) begin
          h_pop          = 1'b1;
          h_push         = accept;
          {re_nx, im_nx} = h_data;
          state_nx       = RUN;
        end else if (accept) begin
          re_nx    = bus.ant_re_i;
          im_nx    = bus.ant_im_i;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
        if (state == IDLE && state_nx == RUN && cnt == '0) begin
          blk_nx = bus.blksize_i;
        end
      end
    end

    en_nx = (state_nx == RUN);
    // sw is registered, so it is raised on entry to the final phase.
    sw_nx = en_nx && (phase_nx == LAST_PHASE) && (cnt_nx == blk_nx);
  end

  // State and output registers.
  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      cnt      <= '0;
      blk      <= CBITS'(CS_BLKSIZE);
      bank     <= '0;
      re_q     <= '0;
      im_q     <= '0;
      en_q     <= 1'b0;
      sw_q     <= 1'b0;
      enable_d <= 1'b0;
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      cnt      <= cnt_nx;
      blk      <= blk_nx;
      bank     <= bank_nx;
      re_q     <= re_nx;
      im_q     <= im_nx;
      en_q     <= en_nx;
      sw_q     <= sw_nx;
      enable_d <= bus.enable_i;
    end
  end

  assign bus.en         = en_q;
  assign bus.re         = re_q;
  assign bus.im         = im_q;
  assign bus.sw         = sw_q;
  assign bus.bank_o     = bank;
  assign bus.overflow_o = ovf;

endmodule
